// File: rtl/elevator_scan_ctrl.sv
// SCAN (collective) elevator scheduler: latches floor requests into a pending
// mask, sequences floor-to-floor travel and door dwell with a shared timer.
module elevator_scan_ctrl #(
    parameter int FLOORS     = 16,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [4:0]        req_floor,
    output logic [4:0]        cur_floor,
    output logic              moving,
    output logic              dir,
    output logic              door_open,
    output logic [FLOORS-1:0] pending,
    output logic              arrive
);

    localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MOVE = 2'd1;
    localparam logic [1:0] DOOR = 2'd2;

    logic [1:0]        state;
    logic [TW-1:0]     timer;
    logic              req_hit;
    logic              req_here;
    logic              req_next;
    logic [FLOORS-1:0] req_oh;
    logic [FLOORS-1:0] above;
    logic [FLOORS-1:0] below;
    logic [FLOORS-1:0] ahead;
    logic [FLOORS-1:0] behind;
    logic [FLOORS-1:0] next_oh;
    logic [FLOORS:0]   le_mask;
    logic [4:0]        next_floor;

    always_comb begin
        req_hit    = req_valid && (req_floor != 5'd0) && (32'(req_floor) <= FLOORS);
        req_oh     = req_hit ? (FLOORS'(1) << (req_floor - 5'd1)) : '0;
        req_here   = req_hit && (req_floor == cur_floor);
        // le_mask has bits for floors 1..cur_floor; shifted down it covers floors below
        le_mask    = ((FLOORS+1)'(1) << cur_floor) - (FLOORS+1)'(1);
        above      = ~le_mask[FLOORS-1:0];
        below      = le_mask[FLOORS:1];
        ahead      = pending & (dir ? above : below);
        behind     = pending & (dir ? below : above);
        next_floor = dir ? cur_floor + 5'd1 : cur_floor - 5'd1;
        next_oh    = FLOORS'(1) << (next_floor - 5'd1);
        req_next   = req_hit && (req_floor == next_floor);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_floor <= 5'd1;
            dir       <= 1'b1;
            moving    <= 1'b0;
            door_open <= 1'b0;
            pending   <= '0;
            arrive    <= 1'b0;
            timer     <= '0;
        end else begin
            arrive <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_here) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        arrive    <= 1'b1;
                        timer     <= TW'(DOOR_CYC);
                    end else begin
                        pending <= pending | req_oh;
                        if ((ahead != '0) || (behind != '0)) begin
                            if (ahead == '0) dir <= ~dir;
                            moving <= 1'b1;
                            timer  <= TW'(TRAVEL_CYC);
                            state  <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    if (timer > TW'(1)) begin
                        timer   <= timer - TW'(1);
                        pending <= pending | req_oh;
                    end else begin
                        cur_floor <= next_floor;
                        // a request for the floor being reached counts as served
                        if (((pending & next_oh) != '0) || req_next) begin
                            pending   <= (pending | req_oh) & ~next_oh;
                            arrive    <= 1'b1;
                            moving    <= 1'b0;
                            door_open <= 1'b1;
                            timer     <= TW'(DOOR_CYC);
                            state     <= DOOR;
                        end else begin
                            pending <= pending | req_oh;
                            timer   <= TW'(TRAVEL_CYC);
                        end
                    end
                end
                DOOR: begin
                    if (req_here) begin
                        timer <= TW'(DOOR_CYC);
                    end else begin
                        pending <= pending | req_oh;
                        if (timer > TW'(1)) begin
                            timer <= timer - TW'(1);
                        end else begin
                            door_open <= 1'b0;
                            if (ahead != '0) begin
                                moving <= 1'b1;
                                timer  <= TW'(TRAVEL_CYC);
                                state  <= MOVE;
                            end else if (behind != '0) begin
                                dir    <= ~dir;
                                moving <= 1'b1;
                                timer  <= TW'(TRAVEL_CYC);
                                state  <= MOVE;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios plus random requests, all
// checked every cycle against a floor/request-set reference model.
module tb_elevator_scan_ctrl;

    localparam int FL = 16;
    localparam int TC = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [4:0]    req_floor = 5'd0;
    logic [4:0]    cur_floor;
    logic          moving;
    logic          dir;
    logic          door_open;
    logic [FL-1:0] pending;
    logic          arrive;

    elevator_scan_ctrl #(.FLOORS(FL), .TRAVEL_CYC(TC), .DOOR_CYC(DC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .cur_floor(cur_floor), .moving(moving), .dir(dir), .door_open(door_open),
        .pending(pending), .arrive(arrive)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stops[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: car position, travel sense, set of requested floors
    typedef enum int {S_IDLE, S_MOVE, S_DOOR} mode_t;
    mode_t m_mode = S_IDLE;
    int    m_floor = 1;
    bit    m_up = 1'b1;
    bit    m_req [1:FL];
    int    m_left = 0;
    bit    m_arrive = 1'b0;

    function automatic bit any_req(input bit up);
        for (int g = 1; g <= FL; g++)
            if (m_req[g] && (up ? (g > m_floor) : (g < m_floor))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy();
        for (int g = 1; g <= FL; g++) if (m_req[g]) return 1'b1;
        return m_mode != S_IDLE;
    endfunction

    task automatic model_step(input bit rst, input bit v, input int f);
        bit hit, here, fwd, back;
        m_arrive = 1'b0;
        if (rst) begin
            m_mode = S_IDLE; m_floor = 1; m_up = 1'b1; m_left = 0;
            foreach (m_req[g]) m_req[g] = 1'b0;
            return;
        end
        hit  = v && f >= 1 && f <= FL;
        here = hit && f == m_floor;
        fwd  = any_req(m_up);
        back = any_req(!m_up);
        case (m_mode)
            S_IDLE: begin
                if (here) begin
                    m_mode = S_DOOR; m_left = DC; m_arrive = 1'b1;
                end else begin
                    if (hit) m_req[f] = 1'b1;
                    if (fwd || back) begin
                        if (!fwd) m_up = !m_up;
                        m_mode = S_MOVE; m_left = TC;
                    end
                end
            end
            S_MOVE: begin
                if (hit) m_req[f] = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    m_floor += m_up ? 1 : -1;
                    if (m_req[m_floor]) begin
                        m_req[m_floor] = 1'b0;
                        m_arrive = 1'b1; m_mode = S_DOOR; m_left = DC;
                    end else begin
                        m_left = TC;
                    end
                end
            end
            S_DOOR: begin
                if (here) begin
                    m_left = DC;
                end else begin
                    if (hit) m_req[f] = 1'b1;
                    m_left--;
                    if (m_left == 0) begin
                        if (fwd) begin
                            m_mode = S_MOVE; m_left = TC;
                        end else if (back) begin
                            m_up = !m_up; m_mode = S_MOVE; m_left = TC;
                        end else begin
                            m_mode = S_IDLE;
                        end
                    end
                end
            end
            default: m_mode = S_IDLE;
        endcase
    endtask

    task automatic compare_all();
        logic [FL-1:0] exp_p;
        for (int g = 1; g <= FL; g++) exp_p[g-1] = m_req[g];
        check("cur_floor", 32'(cur_floor), 32'(m_floor));
        check("moving", 32'(moving), 32'(m_mode == S_MOVE));
        check("door_open", 32'(door_open), 32'(m_mode == S_DOOR));
        check("dir", 32'(dir), 32'(m_up));
        check("pending", 32'(pending), 32'(exp_p));
        check("arrive", 32'(arrive), 32'(m_arrive));
        check("floor_range", 32'(cur_floor >= 5'd1 && cur_floor <= 5'(FL)), 32'd1);
        check("move_door_excl", 32'(!(moving && door_open)), 32'd1);
    endtask

    task automatic cycle(input bit rst, input bit v, input int f);
        reset = rst; req_valid = v; req_floor = 5'(f);
        @(posedge clk);
        model_step(rst, v, f);
        #1;
        compare_all();
        if (arrive) stops.push_back(int'(cur_floor));
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (n < budget && m_busy()) begin
            cycle(1'b0, 1'b0, 0);
            n++;
        end
        if (n >= budget) check("idle_timeout", 32'(n), 32'(budget - 1));
    endtask

    task automatic run_to(input int fl, input bit need_step, input int budget);
        int n = 0;
        while (n < budget && !(m_floor == fl && m_mode == S_MOVE && (!need_step || m_left == 1))) begin
            cycle(1'b0, 1'b0, 0);
            n++;
        end
        if (n >= budget) check("run_to_timeout", 32'(n), 32'(budget - 1));
    endtask

    initial begin
        int cnt;

        // 1: single trip to floor 5
        cycle(1'b1, 1'b0, 0);
        check("rst_floor", 32'(cur_floor), 32'd1);
        check("rst_dir", 32'(dir), 32'd1);
        cycle(1'b0, 1'b1, 5);
        check("t1_pending", 32'(pending), 32'h0010);
        cycle(1'b0, 1'b0, 0);
        check("t1_moving", 32'(moving), 32'd1);
        for (int e = 2; e <= 20; e++) begin
            cycle(1'b0, 1'b0, 0);
            case (e)
                5:  check("t1_f2", 32'(cur_floor), 32'd2);
                9:  check("t1_f3", 32'(cur_floor), 32'd3);
                13: check("t1_f4", 32'(cur_floor), 32'd4);
                17: begin
                    check("t1_f5", 32'(cur_floor), 32'd5);
                    check("t1_arrive", 32'(arrive), 32'd1);
                    check("t1_door", 32'(door_open), 32'd1);
                    check("t1_pend0", 32'(pending), 32'd0);
                end
                20: begin
                    check("t1_door_off", 32'(door_open), 32'd0);
                    check("t1_still", 32'(moving), 32'd0);
                end
                default: ;
            endcase
        end

        // 2: SCAN ordering 6, 8, then reverse to 2
        cycle(1'b1, 1'b0, 0);
        stops.delete();
        cycle(1'b0, 1'b1, 8);
        run_to(3, 1'b0, 100);
        cycle(1'b0, 1'b1, 6);
        cycle(1'b0, 1'b1, 2);
        run_idle(300);
        check("t2_nstops", 32'(stops.size()), 32'd3);
        if (stops.size() == 3) begin
            check("t2_stop0", 32'(stops[0]), 32'd6);
            check("t2_stop1", 32'(stops[1]), 32'd8);
            check("t2_stop2", 32'(stops[2]), 32'd2);
        end
        check("t2_pend0", 32'(pending), 32'd0);

        // 3: request at current floor while idle, then re-request during dwell
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 4);
        run_idle(200);
        cycle(1'b0, 1'b1, 4);
        check("t3_door", 32'(door_open), 32'd1);
        check("t3_arrive", 32'(arrive), 32'd1);
        check("t3_pend", 32'(pending), 32'd0);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 4);
        cnt = door_open ? 1 : 0;
        for (int i = 0; i < 10 && door_open; i++) begin
            cycle(1'b0, 1'b0, 0);
            if (door_open) cnt++;
        end
        check("t3_hold", 32'(cnt), 32'(DC));

        // 4: out-of-range floors ignored
        run_idle(50);
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 17);
        cycle(1'b0, 1'b0, 0);
        check("t4_pend", 32'(pending), 32'd0);
        check("t4_moving", 32'(moving), 32'd0);

        // 5: reset mid-travel
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 9);
        cycle(1'b0, 1'b1, 10);
        run_to(6, 1'b0, 100);
        check("t5_pre_pend", 32'(pending), 32'h0300);
        cycle(1'b1, 1'b0, 0);
        check("t5_floor", 32'(cur_floor), 32'd1);
        check("t5_moving", 32'(moving), 32'd0);
        check("t5_door", 32'(door_open), 32'd0);
        check("t5_pend", 32'(pending), 32'd0);
        check("t5_dir", 32'(dir), 32'd1);
        check("t5_arrive", 32'(arrive), 32'd0);

        // 6: request arrives on the very edge the car reaches that floor
        stops.delete();
        cycle(1'b0, 1'b1, 9);
        run_to(7, 1'b1, 100);
        cycle(1'b0, 1'b1, 8);
        check("t6_floor", 32'(cur_floor), 32'd8);
        check("t6_arrive", 32'(arrive), 32'd1);
        check("t6_bit8", 32'(pending[7]), 32'd0);
        run_idle(200);
        check("t6_nstops", 32'(stops.size()), 32'd2);

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 999) < 3, $urandom_range(0, 5) == 0, $urandom_range(0, 17));
        end
        run_idle(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
